// File: rtl/add_accumulator.sv
// Batch accumulator for 5-bit {Cout,S} results of a 4-bit ripple adder.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module add_accumulator #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  input  logic [3:0]       S,
  input  logic             Cout,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [4:0]       r_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic [4:0]       w_sample;
  logic [ACC_W:0]   w_sum;
  logic             w_of;
  logic [ACC_W-1:0] w_next;

  assign w_sample = {Cout, S};
  assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(w_sample);
  assign w_of     = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // once clamped, the total stays pinned for the rest of the batch
  assign w_next = (w_of || r_ovf) ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= (len == 4'd0) ? 5'd16
                                        : {1'b0, len};
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_of;
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign acc      = r_acc;
  assign ovf      = r_ovf;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
